// File: rtl/axi_lite_master.sv
// axi_lite_master
// Single-outstanding AXI4-Lite initiator for the load/store unit. Converts a
// byte/half/word load or store into one AXI4-Lite read or write, generating
// write strobes, aligning store data, and extracting/extending load data.
//
// Build option: define AXI_MASTER_ALIGN_CHECK_EN to reject misaligned half and
// word accesses locally (error response, no AXI traffic). Without it, such
// accesses are issued unchanged and bytes past the word boundary are dropped.
module axi_lite_master (
  input  logic        clk,
  input  logic        rst,

  // Load/store request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,

  // Completion
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,

  // AXI4-Lite read address / data
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  output logic [2:0]  axi_arprot,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,

  // AXI4-Lite write address / data / response
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  output logic [2:0]  axi_awprot,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t      state_reg;

  // Latched request attributes needed when the read data comes back
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;

  // Registered AXI and response outputs
  logic [31:0] araddr_reg;
  logic        arvalid_reg;
  logic        rready_reg;
  logic [31:0] awaddr_reg;
  logic        awvalid_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        wvalid_reg;
  logic        bready_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic        req_misaligned;
  logic        aw_done;
  logic        w_done;

  // Only the upper response bit distinguishes SLVERR/DECERR from OKAY/EXOKAY
  logic        unused_resp_lsb;
  assign unused_resp_lsb = axi_rresp[0] ^ axi_bresp[0];

  // Strobe covers the access size, moved to the addressed byte lane; lanes
  // shifted past bit 3 fall off the end of the word.
  function automatic logic [3:0] strobe_for(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  // Right-aligned store data moved to its byte lane
  function automatic logic [31:0] align_wdata(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  // Bring the addressed lane down to bit 0, then truncate and extend
  function automatic logic [31:0] extract_rdata(input logic [31:0] data, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    res = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'd1:    res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

`ifdef AXI_MASTER_ALIGN_CHECK_EN
  // Half needs addr[0]=0; word (size 2 or 3) needs addr[1:0]=0
  assign req_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  // A write channel counts as finished once its valid is low or accepted now
  assign aw_done = !awvalid_reg || axi_awready;
  assign w_done  = !wvalid_reg  || axi_wready;

  // Accept only when idle, and never while reset is held
  assign req_ready = (state_reg == IDLE) && !rst;

  assign axi_araddr  = araddr_reg;
  assign axi_arvalid = arvalid_reg;
  assign axi_arprot  = 3'b000;
  assign axi_rready  = rready_reg;
  assign axi_awaddr  = awaddr_reg;
  assign axi_awvalid = awvalid_reg;
  assign axi_awprot  = 3'b000;
  assign axi_wdata   = wdata_reg;
  assign axi_wstrb   = wstrb_reg;
  assign axi_wvalid  = wvalid_reg;
  assign axi_bready  = bready_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_rdata  = resp_rdata_reg;
  assign resp_err    = resp_err_reg;

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      off_reg        <= 2'd0;
      size_reg       <= 2'd0;
      signed_reg     <= 1'b0;
      araddr_reg     <= 32'd0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      awaddr_reg     <= 32'd0;
      awvalid_reg    <= 1'b0;
      wdata_reg      <= 32'd0;
      wstrb_reg      <= 4'd0;
      wvalid_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            off_reg    <= req_addr[1:0];
            size_reg   <= req_size;
            signed_reg <= req_signed;
            if (req_misaligned) begin
              // Rejected locally: immediate error completion, nothing on AXI
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'd0;
              state_reg      <= DONE;
            end else if (req_we) begin
              awaddr_reg  <= {req_addr[31:2], 2'b00};
              wdata_reg   <= align_wdata(req_wdata, req_addr[1:0]);
              wstrb_reg   <= strobe_for(req_size, req_addr[1:0]);
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              araddr_reg  <= {req_addr[31:2], 2'b00};
              arvalid_reg <= 1'b1;
              state_reg   <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (axi_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi_rvalid) begin
            rready_reg     <= 1'b0;
            resp_rdata_reg <= extract_rdata(axi_rdata, size_reg, off_reg, signed_reg);
            resp_err_reg   <= axi_rresp[1];
            resp_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end

        WR_REQ: begin
          // Address and data channels retire independently
          if (axi_awready) begin
            awvalid_reg <= 1'b0;
          end
          if (axi_wready) begin
            wvalid_reg <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (axi_bvalid) begin
            bready_reg     <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= axi_bresp[1];
            resp_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end

        DONE: begin
          // Single-cycle completion pulse; response fields cleared behind it
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= 32'd0;
          state_reg      <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: expected responses and AXI beats are
// queued at issue time; a reactive slave and a response monitor pop and check.
module tb_axi_lite_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic [2:0]  axi_arprot;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic [2:0]  axi_awprot;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  axi_lite_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;

  exp_t        exp_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  wbeat_t      w_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_resp   = 0;

  // Slave behaviour for the next transaction
  int          ar_wait = 0;
  int          aw_wait = 0;
  int          w_wait  = 0;
  int          r_wait  = 0;
  logic [31:0] s_rdata = 32'd0;
  logic [1:0]  s_rresp = 2'b00;
  logic [1:0]  s_bresp = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Reactive AXI4-Lite slave, evaluated on falling edges
  initial begin
    int          ar_cnt = 0;
    int          aw_cnt = 0;
    int          w_cnt  = 0;
    int          r_cnt  = 0;
    logic        ar_acc_prev = 0, ar_stall_prev = 0;
    logic        aw_acc_prev = 0, aw_stall_prev = 0;
    logic        w_acc_prev  = 0, w_stall_prev  = 0;
    logic [31:0] ar_hold = 0, aw_hold = 0, wd_hold = 0;
    logic [3:0]  ws_hold = 0;
    logic [31:0] ea;
    wbeat_t      eb;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        ar_acc_prev = 0; ar_stall_prev = 0; aw_acc_prev = 0; aw_stall_prev = 0;
        w_acc_prev = 0; w_stall_prev = 0;
      end else begin
        // Read address channel
        if (ar_acc_prev) check("arvalid_drop", axi_arvalid, 0);
        if (ar_stall_prev) begin
          check("arvalid_hold", axi_arvalid, 1);
          check("araddr_hold", axi_araddr, ar_hold);
        end
        ar_acc_prev = 0; ar_stall_prev = 0;
        if (axi_arvalid) begin
          if (ar_cnt == ar_wait) begin
            axi_arready = 1; ar_acc_prev = 1;
            if (ar_q.size() == 0) flag_fail("ar_unexpected", "arvalid with no read expected");
            else begin
              ea = ar_q.pop_front();
              check("araddr", axi_araddr, ea);
              check("arprot", {29'd0, axi_arprot}, 0);
            end
          end else begin
            axi_arready = 0; ar_stall_prev = 1; ar_hold = axi_araddr;
          end
          ar_cnt++;
        end else begin
          axi_arready = 0; ar_cnt = 0;
        end
        // Read data channel
        if (axi_rready) begin
          if (r_cnt >= r_wait) begin
            axi_rvalid = 1; axi_rdata = s_rdata; axi_rresp = s_rresp;
          end else axi_rvalid = 0;
          r_cnt++;
        end else begin
          axi_rvalid = 0; r_cnt = 0;
        end
        // Write address channel
        if (aw_acc_prev) check("awvalid_drop", axi_awvalid, 0);
        if (aw_stall_prev) begin
          check("awvalid_hold", axi_awvalid, 1);
          check("awaddr_hold", axi_awaddr, aw_hold);
        end
        aw_acc_prev = 0; aw_stall_prev = 0;
        if (axi_awvalid) begin
          if (aw_cnt == aw_wait) begin
            axi_awready = 1; aw_acc_prev = 1;
            if (aw_q.size() == 0) flag_fail("aw_unexpected", "awvalid with no write expected");
            else begin
              ea = aw_q.pop_front();
              check("awaddr", axi_awaddr, ea);
              check("awprot", {29'd0, axi_awprot}, 0);
            end
          end else begin
            axi_awready = 0; aw_stall_prev = 1; aw_hold = axi_awaddr;
          end
          aw_cnt++;
        end else begin
          axi_awready = 0; aw_cnt = 0;
        end
        // Write data channel
        if (w_acc_prev) check("wvalid_drop", axi_wvalid, 0);
        if (w_stall_prev) begin
          check("wvalid_hold", axi_wvalid, 1);
          check("wdata_hold", axi_wdata, wd_hold);
          check("wstrb_hold", {28'd0, axi_wstrb}, {28'd0, ws_hold});
        end
        w_acc_prev = 0; w_stall_prev = 0;
        if (axi_wvalid) begin
          if (w_cnt == w_wait) begin
            axi_wready = 1; w_acc_prev = 1;
            if (w_q.size() == 0) flag_fail("w_unexpected", "wvalid with no write expected");
            else begin
              eb = w_q.pop_front();
              check("wdata", axi_wdata, eb.data);
              check("wstrb", {28'd0, axi_wstrb}, {28'd0, eb.strb});
            end
          end else begin
            axi_wready = 0; w_stall_prev = 1; wd_hold = axi_wdata; ws_hold = axi_wstrb;
          end
          w_cnt++;
        end else begin
          axi_wready = 0; w_cnt = 0;
        end
        // Write response channel: answer as soon as bready is seen
        axi_bvalid = axi_bready;
        axi_bresp  = s_bresp;
      end
    end
  end

  // Response monitor: every resp_valid cycle must match one queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          flag_fail("resp_unexpected", $sformatf("resp_valid with nothing outstanding, rdata=0x%08h err=%0d", resp_rdata, resp_err));
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: resp rdata=0x%08h err=%0d at cycle %0d (accepted %0d)", n_resp, resp_rdata, resp_err, cyc, e.t_acc);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          if (e.lat >= 0) check("resp_latency", cyc, e.t_acc + e.lat);
        end
      end
    end
  end

  // Wait (bounded) for the DUT to be ready for a new request; returns on a falling edge
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) flag_fail("wait_idle", "req_ready stuck at 0, required 1");
  endtask

  // Present one request at the current falling edge (req_ready already high)
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input logic axi_traffic, input logic expect_resp,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    exp_t   e;
    wbeat_t b;
    req_valid = 1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd;
    if (axi_traffic) begin
      if (we) begin
        aw_q.push_back({addr[31:2], 2'b00});
        b.data = exp_wdata; b.strb = exp_wstrb;
        w_q.push_back(b);
      end else begin
        ar_q.push_back({addr[31:2], 2'b00});
      end
    end
    if (expect_resp) begin
      e.rdata = exp_rdata; e.err = exp_err; e.t_acc = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic slave_cfg(input int arw, input int aww, input int ww, input int rw,
                           input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br);
    ar_wait = arw; aw_wait = aww; w_wait = ww; r_wait = rw;
    s_rdata = rd; s_rresp = rr; s_bresp = br;
  endtask

  initial begin
    int n;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_size = 0;
    req_signed = 0; req_wdata = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 0);
    check("rst_valids", {26'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, resp_valid}, 0);
    check("rst_araddr", axi_araddr, 0);
    check("rst_awaddr", axi_awaddr, 0);
    check("rst_wdata", axi_wdata, 0);
    check("rst_wstrb", {28'd0, axi_wstrb}, 0);
    check("rst_resp", {resp_rdata[30:0], resp_err}, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 1);

    // Word store, zero-wait slave
    wait_idle(); slave_cfg(0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    issue(1, 32'h0000_4000, 2'd2, 0, 32'h1234_5678, 32'h0, 0, 3, 1, 1, 32'h1234_5678, 4'hF);
    // Byte store to lane 1
    wait_idle();
    issue(1, 32'h0000_4005, 2'd0, 0, 32'h0000_00AB, 32'h0, 0, 3, 1, 1, 32'h0000_AB00, 4'h2);
    // Half store to upper half
    wait_idle();
    issue(1, 32'h0000_4002, 2'd1, 0, 32'h0000_BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEF_0000, 4'hC);

    // Loads from slave word 0x80FF0000
    wait_idle(); slave_cfg(0, 0, 0, 0, 32'h80FF_0000, 2'b00, 2'b00);
    issue(0, 32'h0000_6003, 2'd0, 1, 32'h0, 32'hFFFF_FF80, 0, 3, 1, 1, 32'h0, 4'h0);
    wait_idle();
    issue(0, 32'h0000_6002, 2'd1, 0, 32'h0, 32'h0000_80FF, 0, 3, 1, 1, 32'h0, 4'h0);
    wait_idle();
    issue(0, 32'h0000_6002, 2'd1, 1, 32'h0, 32'hFFFF_80FF, 0, 3, 1, 1, 32'h0, 4'h0);
    wait_idle();
    issue(0, 32'h0000_6002, 2'd0, 1, 32'h0, 32'hFFFF_FFFF, 0, 3, 1, 1, 32'h0, 4'h0);
    wait_idle();
    issue(0, 32'h0000_6000, 2'd0, 0, 32'h0, 32'h0000_0000, 0, 3, 1, 1, 32'h0, 4'h0);
    // Size 3 behaves as word
    wait_idle();
    issue(0, 32'h0000_6000, 2'd3, 1, 32'h0, 32'h80FF_0000, 0, 3, 1, 1, 32'h0, 4'h0);

    // Read with arready held low for 5 cycles
    wait_idle(); slave_cfg(5, 0, 0, 0, 32'h1122_3344, 2'b00, 2'b00);
    issue(0, 32'h0000_7000, 2'd2, 0, 32'h0, 32'h1122_3344, 0, 8, 1, 1, 32'h0, 4'h0);
    // Write with awready 3 cycles ahead of wready
    wait_idle(); slave_cfg(0, 1, 4, 0, 32'h0, 2'b00, 2'b00);
    issue(1, 32'h0000_7004, 2'd2, 0, 32'hCAFE_F00D, 32'h0, 0, 7, 1, 1, 32'hCAFE_F00D, 4'hF);

    // Slave errors
    wait_idle(); slave_cfg(0, 0, 0, 0, 32'h0, 2'b10, 2'b00);
    issue(0, 32'h0000_5000, 2'd2, 0, 32'h0, 32'h0, 1, 3, 1, 1, 32'h0, 4'h0);
    wait_idle(); slave_cfg(0, 0, 0, 0, 32'h0, 2'b00, 2'b11);
    issue(1, 32'h0000_5004, 2'd2, 0, 32'h5555_AAAA, 32'h0, 1, 3, 1, 1, 32'h5555_AAAA, 4'hF);

    // Misaligned accesses
    wait_idle(); slave_cfg(0, 0, 0, 0, 32'h80FF_0000, 2'b00, 2'b00);
`ifdef AXI_MASTER_ALIGN_CHECK_EN
    issue(0, 32'h0000_4002, 2'd2, 0, 32'h0, 32'h0, 1, 1, 0, 1, 32'h0, 4'h0);
    wait_idle();
    issue(1, 32'h0000_4001, 2'd1, 0, 32'h0000_BEEF, 32'h0, 1, 1, 0, 1, 32'h0, 4'h0);
`else
    issue(0, 32'h0000_6002, 2'd2, 0, 32'h0, 32'h0000_80FF, 0, 3, 1, 1, 32'h0, 4'h0);
    wait_idle();
    issue(1, 32'h0000_4002, 2'd2, 0, 32'h1122_3344, 32'h0, 0, 3, 1, 1, 32'h3344_0000, 4'hC);
    wait_idle();
    issue(1, 32'h0000_4003, 2'd1, 0, 32'h0000_BEEF, 32'h0, 0, 3, 1, 1, 32'hEF00_0000, 4'h8);
`endif

    // Reset while waiting in RD_DATA: transaction discarded, no response
    wait_idle(); slave_cfg(0, 0, 0, 10, 32'hDEAD_BEEF, 2'b00, 2'b00);
    issue(0, 32'h0000_6000, 2'd2, 0, 32'h0, 32'h0, 0, -1, 1, 0, 32'h0, 4'h0);
    n = 0;
    while (!axi_rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!axi_rready) flag_fail("rd_data_reach", "rready never asserted");
    rst = 1;
    @(negedge clk);
    check("rst_mid_rready", {31'd0, axi_rready}, 0);
    check("rst_mid_arvalid", {31'd0, axi_arvalid}, 0);
    check("rst_mid_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 0);
    rst = 0;
    repeat (3) @(negedge clk);

    // Recovery after reset
    wait_idle(); slave_cfg(0, 0, 0, 0, 32'hA5A5_0F0F, 2'b00, 2'b00);
    issue(0, 32'h0000_6000, 2'd2, 0, 32'h0, 32'hA5A5_0F0F, 0, 3, 1, 1, 32'h0, 4'h0);

    // Drain: every expectation consumed
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("resp_queue_empty", exp_q.size(), 0);
    check("ar_queue_empty", ar_q.size(), 0);
    check("aw_queue_empty", aw_q.size(), 0);
    check("w_queue_empty", w_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
